fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program-counter block.
- Takes the current PC (plus PC+2), drives a multi-cycle instruction memory with a Rd/Done/Stall handshake, and loads the IF/ID pipeline register.
- Back-pressures the PC through PcHold, which is driven into the PC block's hold input.
- Handles decode stalls, branch/jump flushes and halt.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage that sits between the PC block and decode.
// It presents the PC to a multi-cycle instruction memory (Rd/Done/Stall),
// loads the IF/ID register and back-pressures the PC through PcHold.
// It also handles decode stalls, branch/jump flushes and halt.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   PcIn, PcIncIn      PC to fetch and PC+2 from the PC block
//   IMemAddr, IMemRd   memory request address / strobe
//   IMemData/Done/Stall memory response: data, completion, busy
//   IdStall            decode cannot accept; hold IF/ID
//   Flush              squash the fetched or in-flight instruction (redirect)
//   Halt               stop fetching until reset
//   PcHold             1 = PC must not advance
//   IfIdInstr/PcInc/Valid  IF/ID pipeline register
module fetch_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PcIn,
  input  logic [15:0] PcIncIn,
  output logic [15:0] IMemAddr,
  output logic        IMemRd,
  input  logic [15:0] IMemData,
  input  logic        IMemDone,
  input  logic        IMemStall,
  input  logic        IdStall,
  input  logic        Flush,
  input  logic        Halt,
  output logic        PcHold,
  output logic [15:0] IfIdInstr,
  output logic [15:0] IfIdPcInc,
  output logic        IfIdValid
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcinc;
    logic        valid;
  } ifid_t;

  state_t      state, state_nx;
  ifid_t       ifid;
  logic [15:0] req_addr, req_pcinc;
  logic [15:0] buf_instr, buf_pcinc;

  logic        accept;     // request taken by memory this cycle
  logic        cap;        // memory data for a live request arrives this cycle
  logic [15:0] cap_pcinc;
  logic        deliver;    // an instruction is written into IF/ID this cycle
  logic        pending;    // a read is still outstanding after this edge

  assign accept    = (state == S_REQ) && !IMemStall;
  assign cap       = (accept && IMemDone) || ((state == S_WAIT) && IMemDone);
  // A same-cycle hit has not latched req_pcinc yet, so take it from the input.
  assign cap_pcinc = (state == S_REQ) ? PcIncIn : req_pcinc;
  assign deliver   = !Flush && !Halt && !IdStall && (cap || (state == S_HOLD));
  assign pending   = (accept && !IMemDone) ||
                     (((state == S_WAIT) || (state == S_DRAIN)) && !IMemDone);

  assign IMemRd    = (state == S_REQ) && !rst;
  assign IMemAddr  = (state == S_REQ) ? PcIn : req_addr;
  // Flush releases the PC so the redirect target loads; halt pins it.
  assign PcHold    = rst || (state == S_HALTED) || !(Flush || deliver);

  assign IfIdInstr = ifid.instr;
  assign IfIdPcInc = ifid.pcinc;
  assign IfIdValid = ifid.valid;

  always_comb begin
    state_nx = state;
    if (state == S_HALTED)
      state_nx = S_HALTED;
    else if (Flush)
      state_nx = pending ? S_DRAIN : S_REQ;
    else if (Halt)
      state_nx = S_HALTED;
    else begin
      case (state)
        S_REQ:   if (accept) state_nx = IMemDone ? (IdStall ? S_HOLD : S_REQ) : S_WAIT;
        S_WAIT:  if (IMemDone) state_nx = IdStall ? S_HOLD : S_REQ;
        S_HOLD:  if (!IdStall) state_nx = S_REQ;
        S_DRAIN: if (IMemDone) state_nx = S_REQ;
        default: state_nx = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      ifid      <= {NOP_INSTR, 16'h0000, 1'b0};
      req_addr  <= '0;
      req_pcinc <= '0;
      buf_instr <= '0;
      buf_pcinc <= '0;
    end else begin
      state <= state_nx;

      if (accept) begin
        req_addr  <= PcIn;
        req_pcinc <= PcIncIn;
      end

      if (Flush) begin
        buf_instr <= '0;
        buf_pcinc <= '0;
      end else if (!Halt && cap && IdStall) begin
        buf_instr <= IMemData;
        buf_pcinc <= cap_pcinc;
      end

      // IF/ID: flush > delivery > stall hold > bubble. pcinc is kept on bubbles.
      if (Flush) begin
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end else if (deliver) begin
        ifid.instr <= cap ? IMemData  : buf_instr;
        ifid.pcinc <= cap ? cap_pcinc : buf_pcinc;
        ifid.valid <= 1'b1;
      end else if (!IdStall) begin
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PcIn, PcIncIn, IMemAddr, IMemData, IfIdInstr, IfIdPcInc;
  logic        IMemRd, IMemDone, IMemStall, IdStall, Flush, Halt, PcHold, IfIdValid;

  int nerr = 0;
  int nchk = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PcIn(PcIn), .PcIncIn(PcIncIn),
    .IMemAddr(IMemAddr), .IMemRd(IMemRd), .IMemData(IMemData),
    .IMemDone(IMemDone), .IMemStall(IMemStall), .IdStall(IdStall),
    .Flush(Flush), .Halt(Halt), .PcHold(PcHold),
    .IfIdInstr(IfIdInstr), .IfIdPcInc(IfIdPcInc), .IfIdValid(IfIdValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: tracks the outstanding read, the parked instruction and IF/ID.
  logic        m_halted, m_infl, m_dead, m_held, m_valid;
  logic [15:0] m_ipcinc, m_hi, m_hp, m_instr, m_pcinc, m_last;

  task automatic model_reset();
    m_halted = 0; m_infl = 0; m_dead = 0; m_held = 0;
    m_valid = 0; m_instr = 16'h0800; m_pcinc = 0; m_last = 0;
    m_ipcinc = 0; m_hi = 0; m_hp = 0;
  endtask

  task automatic model_cycle();
    logic rd, acc, arr, live, have, ph;
    logic [15:0] ci, cp;
    rd   = !m_halted && !m_infl && !m_held;
    acc  = rd && !IMemStall;
    arr  = (acc && IMemDone) || (m_infl && IMemDone);
    live = arr && !(m_infl && m_dead);
    ph   = 1'b1;
    have = 1'b0; ci = 0; cp = 0;
    chk("m_rd", {15'b0, IMemRd}, {15'b0, rd});
    chk("m_addr", IMemAddr, rd ? PcIn : m_last);
    chk("m_valid", {15'b0, IfIdValid}, {15'b0, m_valid});
    chk("m_instr", IfIdInstr, m_instr);
    if (m_valid) chk("m_pcinc", IfIdPcInc, m_pcinc);
    if (Flush) begin
      m_instr = 16'h0800; m_valid = 0; m_held = 0;
      if ((acc && !IMemDone) || (m_infl && !IMemDone)) begin
        m_infl = 1; m_dead = 1;
      end else m_infl = 0;
      ph = m_halted;
    end else if (Halt || m_halted) begin
      m_halted = 1; m_infl = 0; m_held = 0;
      if (!IdStall) begin m_instr = 16'h0800; m_valid = 0; end
    end else begin
      if (live) begin
        have = 1; ci = IMemData; cp = m_infl ? m_ipcinc : PcIncIn;
      end else if (m_held) begin
        have = 1; ci = m_hi; cp = m_hp;
      end
      if (arr) m_infl = 0;
      if (acc && !IMemDone) begin m_infl = 1; m_dead = 0; m_ipcinc = PcIncIn; end
      if (have && !IdStall) begin
        m_instr = ci; m_pcinc = cp; m_valid = 1; m_held = 0; ph = 0;
      end else if (have) begin
        m_held = 1; m_hi = ci; m_hp = cp;
      end else if (!IdStall) begin
        m_instr = 16'h0800; m_valid = 0;
      end
    end
    if (acc) m_last = PcIn;
    chk("m_pchold", {15'b0, PcHold}, {15'b0, ph});
  endtask

  task automatic drv(input logic [15:0] pc, input logic st, input logic dn,
                     input logic [15:0] dat, input logic ids, input logic fl, input logic hl);
    PcIn = pc; PcIncIn = pc + 16'd2; IMemStall = st; IMemDone = dn;
    IMemData = dat; IdStall = ids; Flush = fl; Halt = hl;
  endtask

  // From a negedge: check this cycle against the model, advance to the next negedge.
  task automatic cyc();
    #1 model_cycle();
    @(negedge clk);
  endtask

  // Memory responder used by the random phase.
  logic mp;
  int   mcnt;

  task automatic rand_drive();
    logic mrd;
    int lat;
    mrd = !m_halted && !m_infl && !m_held;
    drv(16'($urandom) & 16'hfffe, 0, 0, 16'($urandom),
        $urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(79) == 0);
    if (mp) begin
      if (mcnt == 0) begin IMemDone = 1; mp = 0; end
      else mcnt--;
    end else if (mrd) begin
      IMemStall = ($urandom_range(3) == 0);
      if (IMemStall) IMemDone = 1'($urandom_range(1));
      else begin
        lat = $urandom_range(3);
        if (lat == 0) IMemDone = 1;
        else begin mp = 1; mcnt = lat - 1; end
      end
    end
  endtask

  initial begin
    rst = 1; mp = 0; mcnt = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", {15'b0, IMemRd}, 16'h0);
    chk("rst_pchold", {15'b0, PcHold}, 16'h1);
    chk("rst_valid", {15'b0, IfIdValid}, 16'h0);
    chk("rst_instr", IfIdInstr, 16'h0800);
    chk("rst_pcinc", IfIdPcInc, 16'h0);
    rst = 0;

    // single-cycle memory, back-to-back delivery
    for (int i = 0; i < 3; i++) begin
      drv(16'(2 * i), 0, 1, 16'(16'h4001 + i), 0, 0, 0);
      #1 chk("t1_pchold", {15'b0, PcHold}, 16'h0);
      cyc();
      chk("t1_instr", IfIdInstr, 16'(16'h4001 + i));
      chk("t1_pcinc", IfIdPcInc, 16'(2 * i + 2));
    end

    // stalled twice, accepted, done three cycles later
    for (int i = 0; i < 5; i++) begin
      drv(16'h0010, i < 2, 0, 0, 0, 0, 0);
      #1 chk("t2_addr", IMemAddr, 16'h0010);
      chk("t2_pchold", {15'b0, PcHold}, 16'h1);
      cyc();
    end
    drv(16'h0010, 0, 1, 16'h5555, 0, 0, 0);
    #1 chk("t2_done_pchold", {15'b0, PcHold}, 16'h0);
    cyc();
    chk("t2_instr", IfIdInstr, 16'h5555);
    chk("t2_valid", {15'b0, IfIdValid}, 16'h1);
    chk("t2_pcinc", IfIdPcInc, 16'h0012);

    // decode stall on the Done cycle parks the instruction
    drv(16'h0040, 0, 1, 16'h1234, 1, 0, 0);
    #1 chk("t3_pchold", {15'b0, PcHold}, 16'h1);
    cyc();
    chk("t3_unchanged", IfIdInstr, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      drv(16'h0040, 0, 0, 0, 1, 0, 0);
      #1 chk("t3_hold_rd", {15'b0, IMemRd}, 16'h0);
      cyc();
    end
    drv(16'h0040, 0, 0, 0, 0, 0, 0);
    #1 chk("t3_release_pchold", {15'b0, PcHold}, 16'h0);
    cyc();
    chk("t3_instr", IfIdInstr, 16'h1234);
    chk("t3_pcinc", IfIdPcInc, 16'h0042);

    // flush during WAIT; the late data is dropped
    drv(16'h0020, 0, 0, 0, 0, 0, 0); cyc();
    drv(16'h0020, 0, 0, 0, 0, 1, 0);
    #1 chk("t4_flush_pchold", {15'b0, PcHold}, 16'h0);
    cyc();
    chk("t4_flush_instr", IfIdInstr, 16'h0800);
    chk("t4_flush_valid", {15'b0, IfIdValid}, 16'h0);
    drv(16'h0100, 0, 1, 16'hbeef, 0, 0, 0);
    #1 chk("t4_drain_rd", {15'b0, IMemRd}, 16'h0);
    cyc();
    chk("t4_no_beef", IfIdInstr, 16'h0800);
    drv(16'h0100, 0, 1, 16'h7777, 0, 0, 0);
    #1 chk("t4_new_addr", IMemAddr, 16'h0100);
    cyc();
    chk("t4_instr", IfIdInstr, 16'h7777);

    // halt while fetching, then async reset mid-cycle
    drv(16'h002e, 0, 1, 16'h9999, 0, 0, 0); cyc();
    drv(16'h0030, 0, 0, 0, 1, 0, 1); cyc();
    for (int i = 0; i < 20; i++) begin
      drv(16'h0030, 0, i == 0, 16'hbeef, 1, 0, 0);
      #1 chk("t5_halt_rd", {15'b0, IMemRd}, 16'h0);
      chk("t5_halt_pchold", {15'b0, PcHold}, 16'h1);
      cyc();
    end
    chk("t5_kept", IfIdInstr, 16'h9999);
    #2 rst = 1;
    model_reset(); mp = 0;
    #1 chk("t5_rst_valid", {15'b0, IfIdValid}, 16'h0);
    chk("t5_rst_instr", IfIdInstr, 16'h0800);
    @(negedge clk);
    rst = 0;
    drv(16'h0050, 0, 1, 16'haaaa, 0, 0, 0); cyc();
    chk("t5_resume", IfIdInstr, 16'haaaa);

    // flush + decode stall while holding
    drv(16'h0060, 0, 1, 16'hcccc, 1, 0, 0); cyc();
    drv(16'h0060, 0, 0, 0, 1, 1, 0);
    #1 chk("t6_pchold", {15'b0, PcHold}, 16'h0);
    cyc();
    chk("t6_instr", IfIdInstr, 16'h0800);
    chk("t6_valid", {15'b0, IfIdValid}, 16'h0);
    drv(16'h0200, 0, 1, 16'hdddd, 0, 0, 0); cyc();
    chk("t6_new", IfIdInstr, 16'hdddd);
    chk("t6_pcinc", IfIdPcInc, 16'h0202);

    // randomized traffic against the model
    for (int b = 0; b < 6; b++) begin
      rst = 1; drv(0, 0, 0, 0, 0, 0, 0);
      model_reset(); mp = 0;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 150; i++) begin
        rand_drive();
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
